// File: rtl/hazard_controller.sv
// Pipeline hazard controller for the 5-stage RV32I core: stage enables/flushes,
// memory-wait FSM with sticky timeout, and saturating stall/flush counters.
module hazard_controller #(
  parameter int unsigned WAIT_MAX = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_rd_wren_i,
  input  logic             ex_is_load_i,
  input  logic             ex_redirect_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  input  logic             clr_cnt_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_en_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_en_o,
  output logic             mem_wb_flush_o,
  output logic             state_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_t;

  localparam logic [7:0]       LP_WAIT_MAX = 8'(WAIT_MAX);
  localparam logic [CNT_W-1:0] LP_CNT_MAX  = '1;

  logic             w_freeze;
  logic             w_rs1_hit;
  logic             w_rs2_hit;
  logic             w_load_use;
  logic             w_stall_evt;
  logic             w_flush_evt;
  logic             w_timeout_set;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_wait_cnt;
  logic             r_timeout;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign w_freeze   = mem_req_i & ~mem_ready_i;
  assign w_rs1_hit  = id_rs1_used_i & (id_rs1_addr_i == ex_rd_addr_i);
  assign w_rs2_hit  = id_rs2_used_i & (id_rs2_addr_i == ex_rd_addr_i);
  assign w_load_use = ex_is_load_i & ex_rd_wren_i & (ex_rd_addr_i != 5'd0)
                    & (w_rs1_hit | w_rs2_hit);

  // A redirect makes the ID instruction wrong-path, so its load-use stall is not counted.
  assign w_stall_evt   = w_freeze | (w_load_use & ~ex_redirect_i);
  assign w_flush_evt   = ~w_freeze & ex_redirect_i;
  assign w_timeout_set = w_freeze & (r_wait_cnt == LP_WAIT_MAX - 8'd1);

  always_comb begin
    // NOTE: every output gets its default first so no path leaves one unassigned (no latch).
    pc_en_o        = 1'b1;
    if_id_en_o     = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_en_o     = 1'b1;
    id_ex_flush_o  = 1'b0;
    ex_mem_en_o    = 1'b1;
    mem_wb_flush_o = 1'b0;
    if (w_freeze) begin
      pc_en_o        = 1'b0;
      if_id_en_o     = 1'b0;
      id_ex_en_o     = 1'b0;
      ex_mem_en_o    = 1'b0;
      mem_wb_flush_o = 1'b1;
    end else if (ex_redirect_i) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (w_load_use) begin
      pc_en_o       = 1'b0;
      if_id_en_o    = 1'b0;
      id_ex_flush_o = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is asynchronous active-low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_RUN;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_RUN:  if (w_freeze)  w_state_nxt = ST_WAIT;
      ST_WAIT: if (!w_freeze) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    state_o = (r_state == ST_WAIT);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wait_cnt <= 8'd0;
    end else if (!w_freeze) begin
      r_wait_cnt <= 8'd0;
    end else if (r_wait_cnt != LP_WAIT_MAX) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (clr_cnt_i) begin
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_timeout_set) r_timeout <= 1'b1;
      if (w_stall_evt && r_stall_cnt != LP_CNT_MAX) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_evt && r_flush_cnt != LP_CNT_MAX) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign mem_timeout_o = r_timeout;
  assign stall_cnt_o   = r_stall_cnt;
  assign flush_cnt_o   = r_flush_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed hazard scenarios plus
// randomized traffic, compared against a run-length based reference model.
module tb_hazard_controller;

  localparam int WAIT_MAX = 16;
  localparam int CNT_W    = 8;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [4:0]       id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic             id_rs1_used, id_rs2_used, ex_rd_wren, ex_is_load, ex_redirect;
  logic             mem_req, mem_ready, clr_cnt;
  logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush;
  logic             state;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit m_state;
  int m_run;
  bit m_timeout;
  int m_stall;
  int m_flush;

  hazard_controller #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) u_dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .id_rs1_addr_i  (id_rs1_addr),
    .id_rs2_addr_i  (id_rs2_addr),
    .id_rs1_used_i  (id_rs1_used),
    .id_rs2_used_i  (id_rs2_used),
    .ex_rd_addr_i   (ex_rd_addr),
    .ex_rd_wren_i   (ex_rd_wren),
    .ex_is_load_i   (ex_is_load),
    .ex_redirect_i  (ex_redirect),
    .mem_req_i      (mem_req),
    .mem_ready_i    (mem_ready),
    .clr_cnt_i      (clr_cnt),
    .pc_en_o        (pc_en),
    .if_id_en_o     (if_id_en),
    .if_id_flush_o  (if_id_flush),
    .id_ex_en_o     (id_ex_en),
    .id_ex_flush_o  (id_ex_flush),
    .ex_mem_en_o    (ex_mem_en),
    .mem_wb_flush_o (mem_wb_flush),
    .state_o        (state),
    .mem_timeout_o  (mem_timeout),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_freeze();
    return mem_req && !mem_ready;
  endfunction

  function automatic bit is_load_use();
    return ex_is_load && ex_rd_wren && ex_rd_addr != 5'd0 &&
           ((id_rs1_used && id_rs1_addr == ex_rd_addr) ||
            (id_rs2_used && id_rs2_addr == ex_rd_addr));
  endfunction

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush}
  function automatic logic [6:0] exp_ctl();
    if (is_freeze())        return 7'b0000001;
    else if (ex_redirect)   return 7'b1111110;
    else if (is_load_use()) return 7'b0001110;
    else                    return 7'b1101010;
  endfunction

  task automatic model_reset();
    m_state = 0; m_run = 0; m_timeout = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model_edge();
    bit fr, lu;
    fr = is_freeze();
    lu = is_load_use();
    m_state = fr;
    m_run   = fr ? m_run + 1 : 0;
    if (clr_cnt) begin
      m_timeout = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (fr && m_run == WAIT_MAX) m_timeout = 1;
      if ((fr || (lu && !ex_redirect)) && m_stall < CNT_MAX) m_stall++;
      if (!fr && ex_redirect && m_flush < CNT_MAX) m_flush++;
    end
  endtask

  task automatic check_all();
    check("ctl", {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush},
          exp_ctl());
    check("state", state, m_state);
    check("timeout", mem_timeout, m_timeout);
    check("stall_cnt", stall_cnt, m_stall);
    check("flush_cnt", flush_cnt, m_flush);
  endtask

  // Inputs are set by the caller just after an edge; outputs are checked mid-cycle.
  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_used = 0; id_rs2_used = 0;
    ex_rd_addr = 0; ex_rd_wren = 0; ex_is_load = 0; ex_redirect = 0;
    mem_req = 0; mem_ready = 0; clr_cnt = 0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ex_is_load = 1; ex_rd_wren = 1; ex_rd_addr = rd;
    id_rs2_addr = rd; id_rs2_used = 1;
  endtask

  task automatic clear_counters();
    idle(); clr_cnt = 1; step(); clr_cnt = 0;
  endtask

  initial begin
    int burst;
    idle();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Reset state with idle inputs
    step();

    // Load-use on x5 via rs2: one bubble, then everything enabled
    set_load_use(5'd5); step();
    idle(); step();
    check("lu_stall_cnt", stall_cnt, 1);

    // Load to x0 never stalls
    clear_counters();
    ex_is_load = 1; ex_rd_wren = 1; ex_rd_addr = 0;
    id_rs1_addr = 0; id_rs1_used = 1; step();
    idle(); step();
    check("x0_stall_cnt", stall_cnt, 0);

    // Redirect beats load-use
    set_load_use(5'd7); ex_redirect = 1; step();
    idle(); step();
    check("redir_flush_cnt", flush_cnt, 1);
    check("redir_stall_cnt", stall_cnt, 0);

    // Three frozen cycles with a redirect held across the window
    clear_counters();
    mem_req = 1; mem_ready = 0; ex_redirect = 1;
    repeat (3) step();
    check("wait_state", state, 1);
    mem_ready = 1; step();
    idle(); step();
    check("wait_stall_cnt", stall_cnt, 3);
    check("wait_flush_cnt", flush_cnt, 1);
    check("wait_release_state", state, 0);

    // Timeout after WAIT_MAX frozen edges, then clear
    clear_counters();
    mem_req = 1; mem_ready = 0;
    repeat (WAIT_MAX - 1) step();
    check("timeout_before", mem_timeout, 0);
    step();
    check("timeout_at", mem_timeout, 1);
    repeat (4) step();
    idle(); step();
    check("timeout_sticky", mem_timeout, 1);
    clear_counters();
    idle(); step();
    check("timeout_cleared", mem_timeout, 0);
    check("clr_stall_cnt", stall_cnt, 0);

    // Stall counter saturation
    mem_req = 1; mem_ready = 0;
    repeat (CNT_MAX + 5) step();
    idle(); step();
    check("stall_sat", stall_cnt, CNT_MAX);
    clear_counters();

    // Asynchronous reset in the middle of a wait
    mem_req = 1; mem_ready = 0; ex_redirect = 1;
    repeat (3) step();
    #2 rst_n = 0;
    #1;
    model_reset();
    check("rst_state", state, 0);
    check("rst_timeout", mem_timeout, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
    check("rst_ctl_frozen", {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
                             mem_wb_flush}, exp_ctl());
    @(posedge clk);
    #1;
    idle();
    rst_n = 1;
    step();

    // Randomized traffic
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      id_rs1_addr = 5'($urandom_range(0, 3));
      id_rs2_addr = 5'($urandom_range(0, 3));
      ex_rd_addr  = 5'($urandom_range(0, 3));
      id_rs1_used = 1'($urandom_range(0, 1));
      id_rs2_used = 1'($urandom_range(0, 1));
      ex_rd_wren  = 1'($urandom_range(0, 1));
      ex_is_load  = 1'($urandom_range(0, 1));
      ex_redirect = ($urandom_range(0, 3) == 0);
      clr_cnt     = ($urandom_range(0, 149) == 0);
      if (burst > 0) begin
        mem_req = 1; mem_ready = 0; burst--;
      end else begin
        mem_req   = 1'($urandom_range(0, 1));
        mem_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 60) == 0) burst = $urandom_range(14, 20);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
